// File: rtl/dma_pkg.sv
// Shared DMA definitions: FSM state encoding and default geometry, used by
// both the read and write DMA engines.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } dma_state_t;

  localparam int DMA_WORD_SIZE         = 16;
  localparam int DMA_MEM_ADDRESS_WIDTH = 10;
  localparam int DMA_BUFFER_SIZE       = 120;

endpackage : dma_pkg

// File: rtl/dma_writer.sv
// Write-side DMA: streams the first N words of a local result buffer into
// word-addressed memory, one word per clock from a latched base address,
// then pulses o_done for one cycle.
module dma_writer
  import dma_pkg::*;
#(
  parameter int BUFFER_SIZE       = DMA_BUFFER_SIZE,
  parameter int WORD_SIZE         = DMA_WORD_SIZE,
  parameter int MEM_ADDRESS_WIDTH = DMA_MEM_ADDRESS_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_write,
  input  logic [MEM_ADDRESS_WIDTH-1:0]           i_address,
  input  logic [MEM_ADDRESS_WIDTH-1:0]           i_count,
  input  logic [0:BUFFER_SIZE-1][WORD_SIZE-1:0]  i_buffer,
  output logic [MEM_ADDRESS_WIDTH-1:0]           o_mem_addr,
  output logic [WORD_SIZE-1:0]                   o_mem_data,
  output logic                                   o_mem_we,
  output logic                                   o_busy,
  output logic                                   o_done
);

  localparam int IDX_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [MEM_ADDRESS_WIDTH-1:0] BUF_MAX_ADDR = MEM_ADDRESS_WIDTH'(BUFFER_SIZE);
  localparam logic [IDX_W-1:0]             BUF_MAX_IDX  = IDX_W'(BUFFER_SIZE);

  dma_state_t                   state_q;
  // idx_q counts words already issued; it doubles as the index of the next word.
  logic [IDX_W-1:0]             idx_q;
  logic [IDX_W-1:0]             cnt_q;
  logic [MEM_ADDRESS_WIDTH-1:0] base_q;
  logic [MEM_ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [WORD_SIZE-1:0]         mem_data_q;
  logic                         mem_we_q;
  logic                         busy_q;
  logic                         done_q;

  logic [IDX_W-1:0]             cnt_d;

  // Clamp the requested length to the buffer size so the word mux never goes out of range.
  always_comb begin
    // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
    cnt_d = IDX_W'(i_count);
    if (i_count > BUF_MAX_ADDR) begin
      cnt_d = BUF_MAX_IDX;
    end
  end

  // Transfer FSM with registered memory-port outputs; the first word is issued on the start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_write) begin
            base_q <= i_address;
            cnt_q  <= cnt_d;
            busy_q <= 1'b1;
            if (cnt_d != '0) begin
              state_q    <= WRITE;
              mem_we_q   <= 1'b1;
              mem_addr_q <= i_address;
              mem_data_q <= i_buffer[0];
              idx_q      <= IDX_W'(1);
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              idx_q   <= '0;
            end
          end
        end
        WRITE: begin
          if (idx_q == cnt_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= base_q + MEM_ADDRESS_WIDTH'(idx_q);
            mem_data_q <= i_buffer[idx_q];
            idx_q      <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_mem_we   = mem_we_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule : dma_writer

// File: tb/tb_dma_writer.sv
// Self-checking bench for dma_writer: directed scenarios plus random jobs,
// checked cycle by cycle against a job-level timing model.
module tb_dma_writer;

  localparam int BS = 120;
  localparam int WS = 16;
  localparam int AW = 10;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    i_write;
  logic [AW-1:0]           i_address;
  logic [AW-1:0]           i_count;
  logic [0:BS-1][WS-1:0]   tb_buf;
  logic [AW-1:0]           o_mem_addr;
  logic [WS-1:0]           o_mem_data;
  logic                    o_mem_we;
  logic                    o_busy;
  logic                    o_done;

  int vectors    = 0;
  int miscompares = 0;

  // Model of the values the memory port holds while idle.
  int last_addr = 0;
  int last_data = 0;

  dma_writer #(
    .BUFFER_SIZE      (BS),
    .WORD_SIZE        (WS),
    .MEM_ADDRESS_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_write   (i_write),
    .i_address (i_address),
    .i_count   (i_count),
    .i_buffer  (tb_buf),
    .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data),
    .o_mem_we  (o_mem_we),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input string tag, input int we, input int addr, input int data,
                            input int busy, input int done);
    check({tag, " we"},   32'(o_mem_we),   32'(we));
    check({tag, " addr"}, 32'(o_mem_addr), 32'(addr));
    check({tag, " data"}, 32'(o_mem_data), 32'(data));
    check({tag, " busy"}, 32'(o_busy),     32'(busy));
    check({tag, " done"}, 32'(o_done),     32'(done));
  endtask

  // Called at the negedge of the first cycle after the start edge. Checks every
  // cycle through the trailing IDLE cycle. Scrambles i_address/i_count right after
  // the start; at cycle hold_k raises i_write with a new job's parameters.
  task automatic follow_job(input string name, input int base, input int cnt_raw,
                            input int hold_k, input int nb, input int nc);
    int cnt;
    cnt = (cnt_raw > BS) ? BS : cnt_raw;
    for (int k = 0; k <= cnt + 1; k++) begin
      if (k < cnt) begin
        last_addr = (base + k) % (1 << AW);
        last_data = int'(tb_buf[k]);
        check_port($sformatf("%s c%0d", name, k), 1, last_addr, last_data, 1, 0);
      end else if (k == cnt) begin
        check_port($sformatf("%s c%0d", name, k), 0, last_addr, last_data, 1, 1);
      end else begin
        check_port($sformatf("%s c%0d", name, k), 0, last_addr, last_data, 0, 0);
      end
      if (k == 0) begin
        i_address = AW'($urandom);
        i_count   = AW'($urandom);
      end
      if (k == hold_k) begin
        i_write   = 1'b1;
        i_address = AW'(nb);
        i_count   = AW'(nc);
      end
      if (k <= cnt) @(negedge clk);
    end
  endtask

  // Called at a negedge of an IDLE cycle: the next posedge is the start edge.
  task automatic start_job(input string name, input int base, input int cnt_raw);
    i_write   = 1'b1;
    i_address = AW'(base);
    i_count   = AW'(cnt_raw);
    @(negedge clk);
    i_write = 1'b0;
    follow_job(name, base, cnt_raw, -1, 0, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < BS; i++) tb_buf[i] = WS'($urandom);
  endtask

  initial begin
    rst_n     = 1'b0;
    i_write   = 1'b0;
    i_address = '0;
    i_count   = '0;
    for (int i = 0; i < BS; i++) tb_buf[i] = WS'(16'hA000 + i);
    repeat (3) @(negedge clk);
    check_port("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_port("idle", 0, 0, 0, 0, 0);

    // Basic 4-word job.
    start_job("basic", 'h010, 4);

    // Zero-length job: only the done pulse.
    start_job("zero", 'h123, 0);

    // Oversized request clamps to the buffer size.
    fill_random();
    start_job("clamp", 'h200, 200);
    start_job("full", 'h001, BS);

    // Address wrap past the top of memory.
    start_job("wrap", 'h3FE, 4);

    // Start during WRITE and held through DONE: ignored until the trailing IDLE cycle.
    fill_random();
    i_write   = 1'b1;
    i_address = AW'('h100);
    i_count   = AW'(5);
    @(negedge clk);
    i_write = 1'b0;
    follow_job("busyA", 'h100, 5, 2, 'h2F0, 3);
    start_job("busyB", 'h2F0, 3);

    // Reset mid-transfer aborts with no done pulse.
    i_write   = 1'b1;
    i_address = AW'('h050);
    i_count   = AW'(50);
    repeat (6) @(negedge clk);
    i_write = 1'b0;
    check("abort pre we", 32'(o_mem_we), 32'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_port("abort rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    last_addr = 0;
    last_data = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_port($sformatf("abort post c%0d", k), 0, 0, 0, 0, 0);
    end

    // Random jobs.
    for (int j = 0; j < 12; j++) begin
      fill_random();
      start_job($sformatf("rnd%0d", j), int'($urandom_range(0, (1 << AW) - 1)),
                int'($urandom_range(0, BS + 10)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dma_writer
